button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
- REQ-001 SHALL have parameter DB_CYCLES, default 16: consecutive stable synchronised samples required to accept a level change; legal range 2..65535.
- REQ-002 SHALL have parameter REPEAT_CYCLES, default 64: auto-repeat period in clk cycles; used only when DEBOUNCE_AUTOREPEAT_EN is defined.
- REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
- REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port btn_in, input, 1 bit: raw, asynchronous, bouncing push-button level, active-high.
- REQ-006 SHALL have port btn_level, output, 1 bit: registered debounced button level.
- REQ-007 SHALL have port btn_pulse, output, 1 bit: registered single-cycle press strobe, driving the display stage's enable input directly.

Function
- REQ-008 SHALL pass btn_in through a two-flop synchroniser; only the second-stage output (sync) drives the FSM.
- REQ-009 SHALL implement four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- REQ-010 IDLE: when sync=1, SHALL go to PRESS_WAIT with the counter cleared to 0.
- REQ-011 PRESS_WAIT: when sync=0, SHALL return to IDLE.
- REQ-012 PRESS_WAIT: when sync=1 and counter=DB_CYCLES-1, SHALL go to PRESSED; otherwise SHALL increment the counter.
- REQ-013 PRESSED: when sync=0, SHALL go to RELEASE_WAIT with the counter cleared.
- REQ-014 RELEASE_WAIT: when sync=1, SHALL return to PRESSED with no new pulse.
- REQ-015 RELEASE_WAIT: when sync=0 and counter=DB_CYCLES-1, SHALL go to IDLE; otherwise SHALL increment the counter.
- REQ-016 btn_level SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
- REQ-017 btn_pulse SHALL be 1 only in the first cycle of PRESSED entered from PRESS_WAIT.
- REQ-018 Latency: a btn_in rise sampled at edge N, held stable, SHALL produce btn_pulse=1 and btn_level=1 after edge N+DB_CYCLES+2.
- REQ-019 Release latency: btn_level SHALL fall DB_CYCLES+2 edges after btn_in falls and stays low.
- REQ-020 Each accepted press SHALL produce exactly one pulse (autorepeat excluded); no pulse SHALL ever be generated on release.
- REQ-021 The counter SHALL be ceil(log2(DB_CYCLES)) bits wide and SHALL never wrap, because it is cleared on every state entry.

Reset
- REQ-022 While reset=1, the synchroniser flops, counter and repeat counter SHALL be 0, the state SHALL be IDLE, and btn_level=btn_pulse=0, independent of clk.
- REQ-023 Reset asserted mid-count SHALL abort the count with no pending pulse.
- REQ-024 After reset deasserts with btn_in already high, the block SHALL treat the button as a new press (pulse at the REQ-018 latency).

Configuration
- REQ-025 With macro DEBOUNCE_AUTOREPEAT_EN defined, SHALL count cycles while in PRESSED and assert btn_pulse for one cycle each time the count reaches REPEAT_CYCLES.
- REQ-026 Under DEBOUNCE_AUTOREPEAT_EN, the repeat counter SHALL restart at 0 after each repeat pulse and clear on leaving PRESSED.
- REQ-027 Under DEBOUNCE_AUTOREPEAT_EN, the repeat counter SHALL hold, not clear, during RELEASE_WAIT glitches that return to PRESSED.
- REQ-028 Without DEBOUNCE_AUTOREPEAT_EN, the repeat logic SHALL be absent and REPEAT_CYCLES SHALL be ignored.

Structure
- REQ-029 Package button_debounce_pkg SHALL hold the state typedef (db_state_t) and the default constants DB_CYCLES_DEF=16 and REPEAT_CYCLES_DEF=64.
- REQ-030 The synchroniser SHALL be sub-module sync_2ff (clk, reset, d, q), reset to 0.

Verification (clk period 10 ns, DB_CYCLES=16, REPEAT_CYCLES=64)
- REQ-031 Reset 10 ns with btn_in=1, then hold: both outputs 0 during reset; single btn_pulse 18 cycles after release; btn_level=1.
- REQ-032 btn_in toggling every 30 ns for 150 ns, then stable 1 for 300 ns: exactly one pulse, 18 cycles after the final rise.
- REQ-033 Glitch, btn_in=1 for 100 ns then 0: no pulse; btn_level stays 0.
- REQ-034 Press accepted, then three low bursts of 80 ns each: no extra pulse; btn_level stays 1 until 16 stable low samples.
- REQ-035 Reset asserted 8 cycles into PRESS_WAIT: outputs and state return to 0/IDLE immediately; no pulse while reset is held.
- REQ-036 Hold 2000 ns with macro defined: pulses at cycles 18, 82, 146 after the rise; without macro: only cycle 18.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The state encoding and the counter-width helper are used by button_debounce.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_DEF     = 16;
  localparam int REPEAT_CYCLES_DEF = 64;

  // Width for a counter that must reach n-1; never below one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser bringing the raw button level into the clk domain.
// Both stages clear to 0 on reset, so a button held through reset reads as a fresh press.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronised level, debounced level and one press strobe.
// Define DEBOUNCE_AUTOREPEAT_EN to add a repeat strobe every REPEAT_CYCLES while held.
//
// state        | meaning
// IDLE         | button released, waiting for a high sample
// PRESS_WAIT   | high seen, counting stable high samples
// PRESSED      | press accepted, level high
// RELEASE_WAIT | low seen while pressed, counting stable low samples
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db_cycles
    $error("button_debounce: DB_CYCLES must be in 2..65535");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat_cycles
    $error("button_debounce: REPEAT_CYCLES must be at least 1");
  end

  logic          sync;
  db_state_t     state;
  logic [CW-1:0] cnt;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int            RW       = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_cnt;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      btn_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
`ifdef DEBOUNCE_AUTOREPEAT_EN
          else if (rpt_cnt == RPT_LAST) begin
            rpt_cnt   <= '0;
            btn_pulse <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          // A bounce back high resumes the press; the repeat count is kept.
          if (sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus random button traffic.
// The reference accepts a new level once the raw input agrees on DB+1 consecutive samples.
module tb_button_debounce;
  import button_debounce_pkg::*;

  localparam int DB  = 16;
  localparam int RPT = 64;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_pulse = 0;
  int last_pulse = -1;
  int last_fall = -1;
  int rise_at = 0;
  int fall_at = 0;
  logic prev_level = 1'b0;

  button_debounce #(.DB_CYCLES(DB), .REPEAT_CYCLES(RPT)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: raw samples reach the decision two edges late (synchroniser).
  logic q1, q2, run_val, exp_level, exp_pulse;
  int   run_len, rpt;

  task automatic model_step();
    logic s;
    if (reset) begin
      q1 = 0; q2 = 0; run_val = 0; run_len = 0;
      exp_level = 0; exp_pulse = 0; rpt = 0;
    end else begin
      s  = q2;
      q2 = q1;
      q1 = btn_in;
      if (s == run_val) run_len = run_len + 1;
      else begin
        run_val = s;
        run_len = 1;
      end
      exp_pulse = 0;
      if (!exp_level && run_val && run_len >= DB + 1) begin
        exp_level = 1; exp_pulse = 1; rpt = 0;
      end else if (exp_level && !run_val && run_len >= DB + 1) begin
        exp_level = 0; rpt = 0;
      end
`ifdef DEBOUNCE_AUTOREPEAT_EN
      else if (exp_level && run_val && run_len >= 2) begin
        rpt = rpt + 1;
        if (rpt == RPT) begin
          exp_pulse = 1; rpt = 0;
        end
      end
`endif
    end
  endtask

  always @(posedge clk or posedge reset) model_step();

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_b({tag, ":level"}, btn_level, exp_level);
      chk_b({tag, ":pulse"}, btn_pulse, exp_pulse);
      if (btn_pulse === 1'b1) begin
        n_pulse++;
        last_pulse = cyc;
      end
      if (prev_level === 1'b1 && btn_level === 1'b0) last_fall = cyc;
      prev_level = btn_level;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with the button already held down.
    reset  = 1'b1;
    btn_in = 1'b1;
    #2;
    chk_b("rst_level_noclk", btn_level, 1'b0);
    chk_b("rst_pulse_noclk", btn_pulse, 1'b0);
    #5;
    chk_i("rst_state", int'(dut.state), int'(IDLE));
    chk_b("rst_level", btn_level, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    rise_at = cyc + 1;
    n_pulse = 0;
    run(40, "rst_hi");
    chk_i("rst_hi_npulse", n_pulse, 1);
    chk_i("rst_hi_latency", last_pulse - rise_at, DB + 2);
    chk_b("rst_hi_level", btn_level, 1'b1);

    btn_in  = 1'b0;
    fall_at = cyc + 1;
    n_pulse = 0;
    run(40, "release");
    chk_i("release_npulse", n_pulse, 0);
    chk_i("release_latency", last_fall - fall_at, DB + 2);

    // Bouncing press: 3-cycle segments, final rise then stable.
    n_pulse = 0;
    for (int k = 0; k < 5; k++) begin
      btn_in = (k % 2 == 0);
      if (k == 4) rise_at = cyc + 1;
      run(3, "bounce");
    end
    run(30, "bounce_hold");
    chk_i("bounce_npulse", n_pulse, 1);
    chk_i("bounce_latency", last_pulse - rise_at, DB + 2);
    btn_in = 1'b0;
    run(40, "bounce_rel");

    // Short glitch must be rejected.
    n_pulse = 0;
    btn_in = 1'b1;
    run(10, "glitch");
    btn_in = 1'b0;
    run(30, "glitch_low");
    chk_i("glitch_npulse", n_pulse, 0);
    chk_b("glitch_level", btn_level, 1'b0);

    // Accepted press, then low bursts shorter than the debounce window.
    n_pulse = 0;
    btn_in = 1'b1;
    run(25, "press");
    chk_i("press_npulse", n_pulse, 1);
    n_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      btn_in = 1'b0;
      run(8, "burst_low");
      btn_in = 1'b1;
      run(5, "burst_high");
    end
    chk_b("burst_level", btn_level, 1'b1);
    btn_in  = 1'b0;
    fall_at = cyc + 1;
    run(30, "burst_release");
    chk_i("burst_npulse", n_pulse, 0);
    chk_i("burst_fall_latency", last_fall - fall_at, DB + 2);

    // Reset part-way through PRESS_WAIT.
    n_pulse = 0;
    btn_in = 1'b1;
    run(10, "pw");
    chk_i("pw_state", int'(dut.state), int'(PRESS_WAIT));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_b("midrst_level", btn_level, 1'b0);
    chk_b("midrst_pulse", btn_pulse, 1'b0);
    chk_i("midrst_state", int'(dut.state), int'(IDLE));
    chk_i("midrst_cnt", int'(dut.cnt), 0);
    run(30, "in_rst");
    chk_i("in_rst_npulse", n_pulse, 0);
    btn_in = 1'b0;
    reset  = 1'b0;
    run(20, "post_rst");

    // Long hold: one press pulse, plus repeats when enabled.
    n_pulse = 0;
    btn_in  = 1'b1;
    rise_at = cyc + 1;
    run(200, "hold");
`ifdef DEBOUNCE_AUTOREPEAT_EN
    chk_i("hold_npulse", n_pulse, 3);
    chk_i("hold_last", last_pulse - rise_at, DB + 2 + 2 * RPT);
`else
    chk_i("hold_npulse", n_pulse, 1);
    chk_i("hold_last", last_pulse - rise_at, DB + 2);
`endif
    btn_in = 1'b0;
    run(40, "hold_rel");

    // Random segments with occasional asynchronous reset pulses.
    for (int seg = 0; seg < 80; seg++) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) begin
        #3 reset = 1'b1;
        #4 reset = 1'b0;
      end
      run(int'($urandom_range(1, 40)), "rand");
    end
    btn_in = 1'b0;
    run(40, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
